data_memory_arbiter: RTL and testbench

- Two-port arbiter that shares the single-port word-addressed Data_Memory between requester 0 (CPU load/store stage) and requester 1 (debug/DMA loader).
- Grants the memory with round-robin fairness and registers the winner's request.
- Drives the memory's MemWrite/Address/WriteData for exactly one access cycle, then returns ack, read data and a range error to the winner.
- Sits between the requesters and Data_Memory; Data_Memory is instantiated unchanged.

---
 rtl/data_memory_arbiter.sv | 122 ++++++++++++
 tb/tb_data_memory_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between
// a CPU load/store requester (0) and a debug/DMA loader (1).
module data_memory_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,

  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [ADDR_W-3:0] DEPTH_L = (ADDR_W-2)'(DEPTH);

  state_e              state_q, state_d;
  logic                win_q, win_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic                oor_q, oor_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                g0, g1;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                busy;

  // On a tie the requester that was not served last wins.
  assign g0 = p0_req & (~p1_req | last_q);
  assign g1 = p1_req & ~g0;

  assign sel_we    = g1 ? p1_we    : p0_we;
  assign sel_addr  = g1 ? p1_addr  : p0_addr;
  assign sel_wdata = g1 ? p1_wdata : p0_wdata;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    we_d    = we_q;
    oor_d   = oor_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (g0 | g1) begin
          state_d = BUSY;
          win_d   = g1;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          oor_d   = sel_addr[ADDR_W-1:2] >= DEPTH_L;
        end
      end
      BUSY: begin
        state_d = IDLE;
        last_d  = win_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      we_q    <= we_d;
      oor_q   <= oor_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Memory side is driven straight from registered state.
  assign busy      = (state_q == BUSY);
  assign MemWrite  = busy & we_q & ~oor_q;
  assign Address   = addr_q;
  assign WriteData = wdata_q;

  assign p0_ack   = busy & ~win_q;
  assign p1_ack   = busy &  win_q;
  assign p0_err   = p0_ack & oor_q;
  assign p1_err   = p1_ack & oor_q;
  assign p0_rdata = (p0_ack & ~oor_q) ? ReadData : '0;
  assign p1_rdata = (p1_ack & ~oor_q) ? ReadData : '0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter with a behavioural Data_Memory and a
// transaction-level reference model.
module tb_data_memory_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rq [2];
  logic          rwe [2];
  logic [AW-1:0] radr [2];
  logic [DW-1:0] rwd [2];
  logic          ack [2];
  logic          err [2];
  logic [DW-1:0] rdat [2];
  logic          MemWrite;
  logic [AW-1:0] Address;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] ReadData;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p0_req(rq[0]), .p0_we(rwe[0]), .p0_addr(radr[0]), .p0_wdata(rwd[0]),
    .p0_ack(ack[0]), .p0_err(err[0]), .p0_rdata(rdat[0]),
    .p1_req(rq[1]), .p1_we(rwe[1]), .p1_addr(radr[1]), .p1_wdata(rwd[1]),
    .p1_ack(ack[1]), .p1_err(err[1]), .p1_rdata(rdat[1]),
    .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData),
    .ReadData(ReadData)
  );

  // Data_Memory: combinational read, write on posedge.
  assign ReadData = (Address[AW-1:2] < DEPTH) ? mem[Address[7:2]] : 32'hBAD0BAD0;
  always @(posedge clk)
    if (MemWrite && Address[AW-1:2] < DEPTH) mem[Address[7:2]] <= WriteData;

  task automatic idle_reqs();
    for (int i = 0; i < 2; i++) begin
      rq[i] = 0; rwe[i] = 0; radr[i] = '0; rwd[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_reqs();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    idle_reqs();
    reset = 1;
    @(posedge clk); #1;
    total++;
    if ({ack[0], ack[1], err[0], err[1], MemWrite} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl got=%b want=00000", {ack[0], ack[1], err[0], err[1], MemWrite});
    end
    total++;
    if (Address !== '0 || WriteData !== '0 || rdat[0] !== '0 || rdat[1] !== '0) begin
      bad++; $display("FAIL reset_bus addr=%h wd=%h r0=%h r1=%h want 0", Address, WriteData, rdat[0], rdat[1]);
    end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    total++;
    if (ack[0] !== 0 || ack[1] !== 0 || MemWrite !== 0) begin
      bad++; $display("FAIL post_reset_idle ack=%b%b mw=%b want 000", ack[0], ack[1], MemWrite);
    end
  endtask

  task automatic test_store_load();
    rq[0] = 1; rwe[0] = 1; radr[0] = 32'h08; rwd[0] = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if (MemWrite !== 1 || ack[0] !== 1 || err[0] !== 0 || ack[1] !== 0 || Address !== 32'h08) begin
      bad++; $display("FAIL store_busy mw=%b ack0=%b err0=%b ack1=%b addr=%h want 1 1 0 0 8",
                      MemWrite, ack[0], err[0], ack[1], Address);
    end
    rq[0] = 0;
    ref_mem[2] = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if (MemWrite !== 0 || ack[0] !== 0) begin
      bad++; $display("FAIL store_one_cycle mw=%b ack0=%b want 0 0", MemWrite, ack[0]);
    end
    total++;
    if (mem[2] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL store_mem got=%h want=deadbeef", mem[2]);
    end
    rq[1] = 1; rwe[1] = 0; radr[1] = 32'h08;
    total++;
    if (MemWrite !== 0) begin
      bad++; $display("FAIL load_mw_pre got=%b want=0", MemWrite);
    end
    @(negedge clk);
    total++;
    if (ack[1] !== 1 || rdat[1] !== 32'hDEADBEEF || MemWrite !== 0 || err[1] !== 0) begin
      bad++; $display("FAIL p1_load ack=%b rd=%h mw=%b err=%b want 1 deadbeef 0 0",
                      ack[1], rdat[1], MemWrite, err[1]);
    end
    rq[1] = 0;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int exp_who;
    do_reset();
    rq[0] = 1; rwe[0] = 0; radr[0] = 32'h00;
    rq[1] = 1; rwe[1] = 0; radr[1] = 32'h04;
    exp_who = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      total++;
      if (c % 2 == 1) begin
        if (ack[exp_who] !== 1 || ack[1-exp_who] !== 0 || rdat[exp_who] !== ref_mem[exp_who]) begin
          bad++; $display("FAIL fair_c%0d ack=%b%b rd=%h want p%0d rd=%h",
                          c, ack[0], ack[1], rdat[exp_who], exp_who, ref_mem[exp_who]);
        end
        exp_who = 1 - exp_who;
      end else if (ack[0] !== 0 || ack[1] !== 0) begin
        bad++; $display("FAIL fair_gap_c%0d ack=%b%b want 00", c, ack[0], ack[1]);
      end
    end
    idle_reqs();
    @(negedge clk);
  endtask

  task automatic test_oor();
    logic [DW-1:0] w0;
    w0 = mem[0];
    rq[0] = 1; rwe[0] = 1; radr[0] = 32'h100; rwd[0] = 32'hCAFEF00D;
    @(negedge clk);
    total++;
    if (ack[0] !== 1 || err[0] !== 1 || MemWrite !== 0 || rdat[0] !== '0) begin
      bad++; $display("FAIL oor ack=%b err=%b mw=%b rd=%h want 1 1 0 0", ack[0], err[0], MemWrite, rdat[0]);
    end
    rq[0] = 0;
    @(negedge clk);
    total++;
    if (mem[0] !== w0 || mem[0] !== ref_mem[0]) begin
      bad++; $display("FAIL oor_mem got=%h want=%h", mem[0], ref_mem[0]);
    end
  endtask

  task automatic test_reset_busy();
    rq[1] = 1; rwe[1] = 1; radr[1] = 32'h0C; rwd[1] = 32'h12345678;
    @(negedge clk);
    total++;
    if (MemWrite !== 1 || ack[1] !== 1) begin
      bad++; $display("FAIL rb_busy mw=%b ack1=%b want 1 1", MemWrite, ack[1]);
    end
    #1 reset = 1;
    #1;
    total++;
    if (MemWrite !== 0 || ack[1] !== 0) begin
      bad++; $display("FAIL rb_drop mw=%b ack1=%b want 0 0", MemWrite, ack[1]);
    end
    @(negedge clk);
    idle_reqs();
    reset = 0;
    total++;
    if (mem[3] !== 32'h0) begin
      bad++; $display("FAIL rb_mem got=%h want=0", mem[3]);
    end
    rq[0] = 1; radr[0] = 32'h00;
    rq[1] = 1; radr[1] = 32'h04;
    @(negedge clk);
    total++;
    if (ack[0] !== 1 || ack[1] !== 0) begin
      bad++; $display("FAIL rb_tie ack=%b%b want 10", ack[0], ack[1]);
    end
    idle_reqs();
    @(negedge clk);
  endtask

  task automatic test_late_req();
    rq[1] = 1; rwe[1] = 0; radr[1] = 32'h08;
    @(negedge clk);
    rq[1] = 0;
    rq[0] = 1; rwe[0] = 0; radr[0] = 32'h08;
    @(negedge clk);
    total++;
    if (ack[0] !== 0 || ack[1] !== 0) begin
      bad++; $display("FAIL late_idle ack=%b%b want 00", ack[0], ack[1]);
    end
    @(negedge clk);
    total++;
    if (ack[0] !== 1 || rdat[0] !== ref_mem[2]) begin
      bad++; $display("FAIL late_ack ack0=%b rd=%h want 1 %h", ack[0], rdat[0], ref_mem[2]);
    end
    idle_reqs();
    @(negedge clk);
  endtask

  // Transaction-level model: an access occupies one ack cycle followed
  // by one gap cycle; ties go to whoever was not served last.
  task automatic test_random();
    int last, who, idx;
    logic busy_now, e_err, e_we;
    logic [DW-1:0] e_rd;
    do_reset();
    last = 1;
    busy_now = 0; who = 0; e_err = 0; e_we = 0; e_rd = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        total++;
        if (ack[p] !== (busy_now && who == p) ||
            err[p] !== (busy_now && who == p && e_err) ||
            (busy_now && who == p && !e_we && rdat[p] !== e_rd) ||
            (!(busy_now && who == p) && rdat[p] !== '0)) begin
          bad++; $display("FAIL rnd_c%0d_p%0d ack=%b err=%b rd=%h want %b %b %h",
                          c, p, ack[p], err[p], rdat[p], busy_now && who == p,
                          busy_now && who == p && e_err, e_rd);
        end
      end
      total++;
      if (MemWrite !== (busy_now && e_we && !e_err)) begin
        bad++; $display("FAIL rnd_mw_c%0d got=%b want=%b", c, MemWrite, busy_now && e_we && !e_err);
      end
      if (busy_now && e_we && !e_err) ref_mem[radr[who][7:2]] = rwd[who];
      for (int p = 0; p < 2; p++) begin
        if ((busy_now && who == p) || !rq[p]) begin
          rq[p] = ($urandom_range(0, 2) != 0);
          rwe[p] = $urandom_range(0, 1);
          radr[p] = {$urandom_range(0, 79), 2'(($urandom_range(0, 3)))};
          rwd[p] = $urandom;
        end
      end
      if (busy_now) begin
        last = who;
        busy_now = 0;
      end else if (rq[0] || rq[1]) begin
        who = (rq[0] && rq[1]) ? 1 - last : (rq[0] ? 0 : 1);
        idx = int'(radr[who][AW-1:2]);
        e_err = idx >= DEPTH;
        e_we = rwe[who];
        e_rd = e_err ? '0 : ref_mem[idx];
        busy_now = 1;
      end
    end
    @(negedge clk);
    idle_reqs();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (mem[i] !== ref_mem[i]) begin
        bad++; $display("FAIL rnd_mem[%0d] got=%h want=%h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    idle_reqs();
    @(negedge clk);
    test_reset();
    test_store_load();
    test_fairness();
    test_oor();
    test_reset_busy();
    test_late_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
